// File: rtl/fetch_controller.sv
// Instruction fetch controller: issues one imem request at a time, buffers the
// response for decode, and handles redirects by squashing stale responses.
module fetch_controller #(
    parameter int unsigned          WORDSIZE   = 64,
    parameter logic [WORDSIZE-1:0]  RESET_ADDR = '0,
    parameter logic [WORDSIZE-1:0]  INCR       = WORDSIZE'(4)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic                imem_req_valid,
    output logic [WORDSIZE-1:0] imem_req_addr,
    input  logic                imem_req_ready,
    input  logic                imem_resp_valid,
    input  logic [31:0]         imem_resp_data,
    output logic                inst_valid,
    output logic [31:0]         inst_data,
    output logic [WORDSIZE-1:0] inst_pc,
    input  logic                inst_ready,
    input  logic                redirect_valid,
    input  logic [WORDSIZE-1:0] redirect_addr,
    output logic [WORDSIZE-1:0] pc,
    output logic                busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [WORDSIZE-1:0] pc_q, pc_d;
    logic                squash_q, squash_d;
    logic                inst_valid_q, inst_valid_d;
    logic [31:0]         inst_data_q, inst_data_d;
    logic [WORDSIZE-1:0] inst_pc_q, inst_pc_d;
    logic                req_valid_q, req_valid_d;
    logic                busy_q, busy_d;
    logic [WORDSIZE-1:0] redir_tgt;

    // Redirect targets are word aligned.
    assign redir_tgt = redirect_addr & ~WORDSIZE'(3);

    // Next-state and datapath update.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        squash_d     = squash_q;
        inst_valid_d = inst_valid_q;
        inst_data_d  = inst_data_q;
        inst_pc_d    = inst_pc_q;

        if (redirect_valid) begin
            pc_d = redir_tgt;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (imem_req_ready) begin
                    state_d  = ST_WAIT;
                    squash_d = redirect_valid;
                end
            end
            ST_WAIT: begin
                if (imem_resp_valid) begin
                    if (squash_q || redirect_valid) begin
                        squash_d = 1'b0;
                        state_d  = ST_REQ;
                    end else begin
                        inst_valid_d = 1'b1;
                        inst_data_d  = imem_resp_data;
                        inst_pc_d    = pc_q;
                        state_d      = ST_HOLD;
                    end
                end else if (redirect_valid) begin
                    squash_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (redirect_valid) begin
                    inst_valid_d = 1'b0;
                    state_d      = ST_REQ;
                end else if (inst_ready) begin
                    pc_d         = pc_q + INCR;
                    inst_valid_d = 1'b0;
                    state_d      = ST_REQ;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Status outputs are registered from the next state.
        req_valid_d = (state_d == ST_REQ);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_ADDR;
            squash_q     <= 1'b0;
            inst_valid_q <= 1'b0;
            inst_data_q  <= '0;
            inst_pc_q    <= '0;
            req_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            squash_q     <= squash_d;
            inst_valid_q <= inst_valid_d;
            inst_data_q  <= inst_data_d;
            inst_pc_q    <= inst_pc_d;
            req_valid_q  <= req_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = pc_q;
    assign inst_valid     = inst_valid_q;
    assign inst_data      = inst_data_q;
    assign inst_pc        = inst_pc_q;
    assign pc             = pc_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: directed scenarios plus a
// randomized run against a transaction-level model of the fetch flow.
module tb_fetch_controller;

    localparam int unsigned W = 64;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          imem_req_ready = 1'b0;
    logic          imem_resp_valid = 1'b0;
    logic [31:0]   imem_resp_data = '0;
    logic          inst_ready = 1'b0;
    logic          redirect_valid = 1'b0;
    logic [W-1:0]  redirect_addr = '0;

    logic          imem_req_valid, inst_valid, busy;
    logic [W-1:0]  imem_req_addr, inst_pc, pc;
    logic [31:0]   inst_data;

    logic          w_req_valid, w_inst_valid, w_busy;
    logic [W-1:0]  w_req_addr, w_inst_pc, w_pc;
    logic [31:0]   w_inst_data;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fetch_controller dut (
        .clk(clk), .reset(reset), .start(start),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready), .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data), .inst_valid(inst_valid),
        .inst_data(inst_data), .inst_pc(inst_pc), .inst_ready(inst_ready),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .pc(pc), .busy(busy)
    );

    fetch_controller #(.RESET_ADDR(64'hFFFF_FFFF_FFFF_FFFC)) dut_wrap (
        .clk(clk), .reset(reset), .start(start),
        .imem_req_valid(w_req_valid), .imem_req_addr(w_req_addr),
        .imem_req_ready(imem_req_ready), .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data), .inst_valid(w_inst_valid),
        .inst_data(w_inst_data), .inst_pc(w_inst_pc), .inst_ready(inst_ready),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .pc(w_pc), .busy(w_busy)
    );

    // Reference model: running / outstanding fetch / stale flag / offered instruction.
    bit           m_running, m_outstanding, m_stale, m_offer;
    logic [W-1:0] m_pc, m_ipc;
    logic [31:0]  m_idata;

    task automatic model_reset();
        m_running = 0; m_outstanding = 0; m_stale = 0; m_offer = 0;
        m_pc = '0; m_ipc = '0; m_idata = '0;
    endtask

    task automatic model_step();
        logic [W-1:0] tgt;
        tgt = {redirect_addr[W-1:2], 2'b00};
        if (!m_running) begin
            if (redirect_valid) m_pc = tgt;
            if (start) m_running = 1;
        end else if (m_outstanding) begin
            if (imem_resp_valid) begin
                m_outstanding = 0;
                if (m_stale || redirect_valid) begin
                    m_stale = 0;
                    if (redirect_valid) m_pc = tgt;
                end else begin
                    m_offer = 1; m_idata = imem_resp_data; m_ipc = m_pc;
                end
            end else if (redirect_valid) begin
                m_pc = tgt; m_stale = 1;
            end
        end else if (m_offer) begin
            if (redirect_valid) begin
                m_offer = 0; m_pc = tgt;
            end else if (inst_ready) begin
                m_offer = 0; m_pc = m_pc + 64'd4;
            end
        end else begin
            if (redirect_valid) m_pc = tgt;
            if (imem_req_ready) begin
                m_outstanding = 1; m_stale = redirect_valid;
            end
        end
    endtask

    task automatic idle_inputs();
        start = 0; imem_req_ready = 0; imem_resp_valid = 0; imem_resp_data = '0;
        inst_ready = 0; redirect_valid = 0; redirect_addr = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        repeat (2) @(posedge clk);
        #1 reset = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({imem_req_valid, inst_valid, busy, imem_req_addr, inst_pc, pc, inst_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rv=%0b iv=%0b busy=%0b addr=%h ipc=%h pc=%h data=%h, want all 0",
                     imem_req_valid, inst_valid, busy, imem_req_addr, inst_pc, pc, inst_data);
        end
        n_cmp++;
        if (w_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin
            n_fail++;
            $display("FAIL reset_addr_param: got pc=%h want fffffffffffffffc", w_pc);
        end
    endtask

    task automatic test_stream();
        logic [W-1:0] pcs [4];
        int           cyc_at [4];
        int           n;
        do_reset();
        start = 1; imem_req_ready = 1; imem_resp_valid = 1; inst_ready = 1;
        imem_resp_data = 32'h0000_0013;
        n = 0;
        for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
            @(posedge clk); #1;
            start = 0;
            if (inst_valid === 1'b1) begin
                pcs[n] = inst_pc; cyc_at[n] = cyc; n++;
                n_cmp++;
                if (inst_data !== 32'h0000_0013) begin
                    n_fail++;
                    $display("FAIL stream_data: got %h want 00000013", inst_data);
                end
            end
        end
        n_cmp++;
        if (n != 4) begin
            n_fail++;
            $display("FAIL stream_count: got %0d instructions want 4 within 40 cycles", n);
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (pcs[i] !== W'(4 * i)) begin
                    n_fail++;
                    $display("FAIL stream_pc[%0d]: got %h want %h", i, pcs[i], W'(4 * i));
                end
            end
            for (int i = 1; i < 4; i++) begin
                n_cmp++;
                if (cyc_at[i] - cyc_at[i-1] != 3) begin
                    n_fail++;
                    $display("FAIL stream_spacing[%0d]: got %0d cycles want 3", i, cyc_at[i] - cyc_at[i-1]);
                end
            end
        end
        idle_inputs();
    endtask

    task automatic test_wrap();
        logic [W-1:0] addrs [2];
        int           n;
        do_reset();
        start = 1; imem_req_ready = 1; imem_resp_valid = 1; inst_ready = 1;
        n = 0;
        for (int cyc = 0; cyc < 20 && n < 2; cyc++) begin
            @(posedge clk); #1;
            start = 0;
            if (w_req_valid === 1'b1) begin
                addrs[n] = w_req_addr; n++;
            end
        end
        n_cmp++;
        if (n != 2) begin
            n_fail++;
            $display("FAIL wrap_count: got %0d requests want 2", n);
        end else begin
            n_cmp++;
            if (addrs[0] !== 64'hFFFF_FFFF_FFFF_FFFC) begin
                n_fail++;
                $display("FAIL wrap_first: got %h want fffffffffffffffc", addrs[0]);
            end
            n_cmp++;
            if (addrs[1] !== '0) begin
                n_fail++;
                $display("FAIL wrap_next: got %h want 0", addrs[1]);
            end
        end
        idle_inputs();
    endtask

    task automatic test_hold();
        bit got;
        do_reset();
        start = 1; imem_req_ready = 1; imem_resp_valid = 1; inst_ready = 0;
        imem_resp_data = 32'h1234_5678;
        got = 0;
        for (int cyc = 0; cyc < 10 && !got; cyc++) begin
            @(posedge clk); #1;
            start = 0;
            got = (inst_valid === 1'b1);
        end
        n_cmp++;
        if (!got) begin
            n_fail++;
            $display("FAIL hold_timeout: inst_valid=%0b want 1 within 10 cycles", inst_valid);
        end
        imem_resp_data = 32'hFFFF_FFFF;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (inst_valid !== 1'b1 || inst_data !== 32'h1234_5678 || inst_pc !== '0 || imem_req_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_stable[%0d]: got iv=%0b data=%h ipc=%h rv=%0b want iv=1 data=12345678 ipc=0 rv=0",
                         i, inst_valid, inst_data, inst_pc, imem_req_valid);
            end
        end
        inst_ready = 1;
        @(posedge clk); #1;
        n_cmp++;
        if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== W'(4)) begin
            n_fail++;
            $display("FAIL hold_release: got iv=%0b rv=%0b addr=%h want iv=0 rv=1 addr=4",
                     inst_valid, imem_req_valid, imem_req_addr);
        end
        idle_inputs();
    endtask

    task automatic test_redirect();
        do_reset();
        start = 1; imem_req_ready = 1; imem_resp_valid = 0; inst_ready = 1;
        @(posedge clk); #1;
        start = 0;
        n_cmp++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== '0) begin
            n_fail++;
            $display("FAIL redir_first_req: got rv=%0b addr=%h want rv=1 addr=0", imem_req_valid, imem_req_addr);
        end
        @(posedge clk); #1;
        redirect_valid = 1; redirect_addr = W'(32'h103);
        @(posedge clk); #1;
        redirect_valid = 0;
        n_cmp++;
        if (pc !== W'(32'h100) || imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL redir_wait: got pc=%h rv=%0b iv=%0b want pc=100 rv=0 iv=0", pc, imem_req_valid, inst_valid);
        end
        imem_resp_valid = 1; imem_resp_data = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        n_cmp++;
        if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== W'(32'h100)) begin
            n_fail++;
            $display("FAIL redir_drop: got iv=%0b rv=%0b addr=%h want iv=0 rv=1 addr=100",
                     inst_valid, imem_req_valid, imem_req_addr);
        end
        imem_resp_data = 32'hCAFE_F00D;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (inst_valid !== 1'b1 || inst_pc !== W'(32'h100) || inst_data !== 32'hCAFE_F00D) begin
            n_fail++;
            $display("FAIL redir_refetch: got iv=%0b ipc=%h data=%h want iv=1 ipc=100 data=cafef00d",
                     inst_valid, inst_pc, inst_data);
        end
        idle_inputs();
    endtask

    task automatic test_reset_in_wait();
        do_reset();
        start = 1; imem_req_ready = 1; imem_resp_valid = 0;
        repeat (2) @(posedge clk);
        #1;
        start = 0;
        n_cmp++;
        if (busy !== 1'b1 || imem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rstwait_setup: got busy=%0b rv=%0b want busy=1 rv=0", busy, imem_req_valid);
        end
        #2 reset = 1;
        #1;
        n_cmp++;
        if ({imem_req_valid, inst_valid, busy, imem_req_addr, inst_pc, pc, inst_data} !== '0) begin
            n_fail++;
            $display("FAIL rstwait_async: got rv=%0b iv=%0b busy=%0b addr=%h ipc=%h pc=%h data=%h, want all 0",
                     imem_req_valid, inst_valid, busy, imem_req_addr, inst_pc, pc, inst_data);
        end
        @(posedge clk); #1;
        reset = 0; imem_req_ready = 0; imem_resp_valid = 1; imem_resp_data = 32'h5555_AAAA;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (inst_valid !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL rstwait_late_resp[%0d]: got iv=%0b busy=%0b want 0 0", i, inst_valid, busy);
            end
        end
        idle_inputs();
    endtask

    task automatic test_random();
        logic [226:0] got, exp;
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            start           = ($urandom_range(0, 9) == 0);
            imem_req_ready  = ($urandom_range(0, 9) < 6);
            imem_resp_valid = ($urandom_range(0, 1) == 1);
            imem_resp_data  = $urandom;
            inst_ready      = ($urandom_range(0, 1) == 1);
            redirect_valid  = ($urandom_range(0, 9) == 0);
            redirect_addr   = {$urandom, $urandom};
            @(posedge clk);
            model_step();
            #1;
            got = {imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc, pc, busy};
            exp = {m_running && !m_outstanding && !m_offer, m_pc, m_offer, m_idata, m_ipc, m_pc, m_running};
            n_cmp++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL random_cycle[%0d]: got rv,addr,iv,data,ipc,pc,busy=%h want %h", cyc, got, exp);
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_wrap();
        test_hold();
        test_redirect();
        test_reset_in_wait();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter WORDSIZE, default 64, SHALL set the width of all address/PC buses.
REQ-002 Parameter RESET_ADDR, default 0, SHALL be the PC value loaded by reset.
REQ-003 Parameter INCR, default 4, SHALL be the sequential PC step.
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  SHALL be asynchronous and active-high; it clears all state immediately.
REQ-006 start  input  1  SHALL launch fetching from IDLE.
REQ-007 imem_req_valid  output  1  SHALL flag a fetch request.
REQ-008 imem_req_addr  output  WORDSIZE  SHALL carry the address being fetched.
REQ-009 imem_req_ready  input  1  SHALL mean memory accepts the request this cycle.
REQ-010 imem_resp_valid  input  1  SHALL mean imem_resp_data is valid this cycle.
REQ-011 imem_resp_data  input  32  SHALL carry the instruction word.
REQ-012 inst_valid  output  1  SHALL flag an instruction offered to decode.
REQ-013 inst_data  output  32  SHALL carry that instruction.
REQ-014 inst_pc  output  WORDSIZE  SHALL carry that instruction's address.
REQ-015 inst_ready  input  1  SHALL mean decode accepts the instruction this cycle.
REQ-016 redirect_valid  input  1  SHALL request a control-flow change.
REQ-017 redirect_addr  input  WORDSIZE  SHALL give the redirect target.
REQ-018 pc  output  WORDSIZE  SHALL show the current fetch PC.
REQ-019 busy  output  1  SHALL be 1 in every state except IDLE.

Function
REQ-020 FSM states SHALL be IDLE, REQ, WAIT and HOLD.
REQ-021 IDLE: when start=1, the FSM SHALL go to REQ next cycle; redirect in IDLE SHALL update pc only.
REQ-022 REQ: imem_req_valid SHALL be 1 and imem_req_addr SHALL equal pc; when imem_req_ready=1, the FSM SHALL go to WAIT.
REQ-023 WAIT: when imem_resp_valid=1 and squash=0, the block SHALL latch inst_data=imem_resp_data and inst_pc=pc, set inst_valid=1 and go to HOLD.
REQ-024 WAIT: when imem_resp_valid=1 and squash=1, the response SHALL be discarded, squash cleared, and the FSM SHALL go to REQ.
REQ-025 HOLD: inst_valid, inst_data and inst_pc SHALL stay stable until inst_ready=1; on that edge pc SHALL become pc+INCR, inst_valid SHALL clear, and the FSM SHALL go to REQ.
REQ-026 pc+INCR SHALL wrap modulo 2^WORDSIZE (all-ones minus 3 plus 4 gives 0).
REQ-027 redirect_valid=1 SHALL load pc with redirect_addr, with bits [1:0] forced to 0, in every state, overriding the increment.
REQ-028 Redirect in REQ with imem_req_ready=1 in the same cycle SHALL set squash and go to WAIT; without ready, the FSM SHALL stay in REQ with the new address.
REQ-029 Redirect in WAIT SHALL set squash=1; if imem_resp_valid=1 in the same cycle, that response SHALL be discarded and the FSM SHALL go to REQ.
REQ-030 Redirect in HOLD SHALL clear inst_valid and go to REQ; redirect together with inst_ready SHALL count as consumed, and pc SHALL take redirect_addr.
REQ-031 At most one request SHALL be outstanding, and no new request SHALL issue while in WAIT or HOLD.
REQ-032 imem_resp_valid outside WAIT SHALL be ignored.
REQ-033 Minimum fetch latency SHALL be REQ accept to inst_valid in 1 cycle, given a response the cycle after accept.

Reset
REQ-034 While reset=1, the block SHALL force the state to IDLE, pc to RESET_ADDR, squash to 0, inst_valid, imem_req_valid and busy to 0, and inst_data and inst_pc to 0.
REQ-035 Reset asserted in WAIT SHALL forget the outstanding request; any late response SHALL be ignored per REQ-032.

Verification
REQ-036 Reset, then start with ready and response always 1 and inst_ready=1 -> inst_pc sequence 0,4,8,12, with one instruction per 3 cycles.
REQ-037 Hold inst_ready=0 for 5 cycles in HOLD -> inst_valid, inst_data and inst_pc are stable and no imem_req_valid is issued.
REQ-038 redirect_addr=0x103 in WAIT, then response 0xDEADBEEF arrives -> response dropped, next request address is 0x100, and inst_pc is 0x100.
REQ-039 RESET_ADDR=0xFFFF_FFFF_FFFF_FFFC with one instruction consumed -> next imem_req_addr is 0.
REQ-040 Reset asserted mid-WAIT -> all outputs 0 and pc=RESET_ADDR with no clock edge; a later resp_valid does not set inst_valid.
